// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the execute-stage ALU.
//   alu_op_e           4-bit operation code (13..15 are illegal)
//   alu_state_e        control FSM state {IDLE, SHIFT}
//   ALU_OP_ILLEGAL_MIN first illegal opcode value
//   is_shift()         true for SLL/SRL/SRA
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_GE   = 4'd11,
    ALU_GEU  = 4'd12
  } alu_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_e;

  localparam logic [3:0] ALU_OP_ILLEGAL_MIN = 4'd13;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle combinational datapath for every operation,
// including full-width shifts.
//   a, b    operands; b[$clog2(XLEN)-1:0] is the shift amount
//   op      operation code
//   result  operation result (0 for illegal codes)
//   illegal op is outside the defined opcode range
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  assign illegal = (op >= ALU_OP_ILLEGAL_MIN);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      ALU_EQ:   result = {{(XLEN-1){1'b0}}, a == b};
      ALU_GE:   result = {{(XLEN-1){1'b0}}, $signed(a) >= $signed(b)};
      ALU_GEU:  result = {{(XLEN-1){1'b0}}, a >= b};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: handshaked execute-stage ALU with a registered result and an
// optional bit-serial shifter (SHIFT_STEP bits per cycle).
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous flush: drops the output and any shift
//   in_valid/in_ready     request handshake; in_op, in_a, in_b, in_tag payload
//   out_valid/out_ready   result handshake; out_result, out_tag, out_illegal
//   busy                  FSM is in SHIFT
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once out_valid is high, the output payload is stable until the
// edge where out_ready is also high. in_ready never depends on in_valid.
module alu_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 32,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  localparam int              SHW    = $clog2(XLEN);
  localparam logic [SHW:0]    STEP_L = (SHW+1)'(SHIFT_STEP);
  localparam bit              SERIAL = (SHIFT_STEP < XLEN);

  alu_state_e       state, state_n;
  logic [XLEN-1:0]  sh_val, sh_val_n;
  logic [SHW-1:0]   sh_rem, sh_rem_n;
  logic             sh_left, sh_left_n;
  logic             sh_fill, sh_fill_n;
  logic [TAG_W-1:0] sh_tag, sh_tag_n;

  logic             load;
  logic [XLEN-1:0]  load_result;
  logic [TAG_W-1:0] load_tag;
  logic             load_illegal;

  logic [XLEN-1:0]  comb_result;
  logic             comb_illegal;
  logic             slot_free, accept, serial_start;
  logic [SHW-1:0]   shamt;
  logic [SHW:0]     rem_ext, step_amt, rem_after;
  logic [XLEN-1:0]  stepped;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .a       (in_a),
    .b       (in_b),
    .op      (in_op),
    .result  (comb_result),
    .illegal (comb_illegal)
  );

  assign slot_free    = !out_valid || out_ready;
  assign in_ready     = (state == IDLE) && slot_free && !flush;
  assign accept       = in_valid && in_ready;
  assign shamt        = in_b[SHW-1:0];
  assign serial_start = SERIAL && is_shift(in_op) && (shamt != '0);
  assign busy         = (state == SHIFT);

  // One serial step moves min(SHIFT_STEP, rem) bits; right shifts fill
  // with the latched sign bit (zero for SRL).
  assign rem_ext   = {1'b0, sh_rem};
  assign step_amt  = (rem_ext > STEP_L) ? STEP_L : rem_ext;
  assign rem_after = rem_ext - step_amt;
  assign stepped   = sh_left ? (sh_val << step_amt)
                             : ((sh_val >> step_amt) |
                                (sh_fill ? ~({XLEN{1'b1}} >> step_amt) : '0));

  always_comb begin
    state_n      = state;
    sh_val_n     = sh_val;
    sh_rem_n     = sh_rem;
    sh_left_n    = sh_left;
    sh_fill_n    = sh_fill;
    sh_tag_n     = sh_tag;
    load         = 1'b0;
    load_result  = comb_result;
    load_tag     = in_tag;
    load_illegal = comb_illegal;
    case (state)
      IDLE: begin
        if (accept) begin
          if (serial_start) begin
            state_n   = SHIFT;
            sh_val_n  = in_a;
            sh_rem_n  = shamt;
            sh_left_n = (in_op == ALU_SLL);
            sh_fill_n = (in_op == ALU_SRA) && in_a[XLEN-1];
            sh_tag_n  = in_tag;
          end else begin
            load = 1'b1;
          end
        end
      end
      SHIFT: begin
        load_tag     = sh_tag;
        load_illegal = 1'b0;
        if (sh_rem != '0) begin
          sh_val_n = stepped;
          sh_rem_n = rem_after[SHW-1:0];
          // The last step and the output load share an edge, so a shift
          // takes ceil(shamt/SHIFT_STEP) cycles in SHIFT.
          if ((rem_after == '0) && slot_free) begin
            load        = 1'b1;
            load_result = stepped;
            state_n     = IDLE;
          end
        end else if (slot_free) begin
          load        = 1'b1;
          load_result = sh_val;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh_val      <= '0;
      sh_rem      <= '0;
      sh_left     <= 1'b0;
      sh_fill     <= 1'b0;
      sh_tag      <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else begin
      state   <= state_n;
      sh_val  <= sh_val_n;
      sh_rem  <= sh_rem_n;
      sh_left <= sh_left_n;
      sh_fill <= sh_fill_n;
      sh_tag  <= sh_tag_n;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid   <= 1'b1;
        out_result  <= load_result;
        out_tag     <= load_tag;
        out_illegal <= load_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Parametrised, handshaked execute-stage ALU that replaces the per-operation enable-masked wrappers with a single unit. It accepts one operation per transfer over a valid/ready interface and returns a registered result carrying the caller's tag. Shifts optionally run bit-serially, `SHIFT_STEP` bits per cycle, to trade latency for area. The unit sits in s3_execute between operand forwarding and writeback/branch resolution.

## Interface
- `XLEN`, 32: operand and result width; must be a power of 2 and at least 8.
- `SHIFT_STEP`, 32: bits shifted per cycle; must be a power of 2 in the range 1..XLEN. When equal to XLEN, shifts complete in one cycle.
- `TAG_W`, 5: width of the tag passed through unchanged (e.g. rd index).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept a request this cycle.
- `in_op` in 4: operation, type `alu_op_e`.
- `in_a` in XLEN: operand A.
- `in_b` in XLEN: operand B; `b[$clog2(XLEN)-1:0]` is the shift amount.
- `in_tag` in TAG_W: tag.
- `out_valid` out 1: result held in the output register.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out XLEN: result.
- `out_tag` out TAG_W: tag of the result.
- `out_illegal` out 1: the operation code was illegal.
- `busy` out 1: the FSM is not IDLE.

## Operation
- Opcodes:
  - ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7.
  - SLT=8, SLTU=9, EQ=10, GE=11, GEU=12.
  - 13–15 are illegal.
- Arithmetic wraps modulo 2^XLEN. No overflow or carry outputs.
- Compare ops (SLT..GEU) return zero-extended 1 or 0. SLT and GE are signed; SLTU and GEU are unsigned.
- Illegal op: result 0, `out_illegal`=1, 1-cycle latency. Not an error stall.
- SRA fills with sign bit `a[XLEN-1]`. SLL and SRL fill with 0.
- Transfer occurs when `in_valid && in_ready`.
- `in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush`.
- FSM states:
  - IDLE → IDLE, loading the output register, on accept of a non-shift op, a shift with shamt=0, or any shift when SHIFT_STEP==XLEN.
  - IDLE → SHIFT on accept of a shift with shamt>0 and SHIFT_STEP<XLEN. Latches operand, direction, fill bit, remaining count `rem`=shamt, and tag.
  - SHIFT: each cycle with rem>0, shift by `min(SHIFT_STEP, rem)` and decrement rem accordingly.
  - SHIFT → IDLE at the edge where rem=0 and the output slot is free (`!out_valid || out_ready`); the result loads into the output register.
  - SHIFT with rem=0 and the output slot occupied: hold the shift state until the slot frees.
- Output register:
  - Once valid, `out_valid`, `out_result`, `out_tag` and `out_illegal` are held stable until `out_ready`.
  - Drain and new load in the same cycle is allowed (full throughput, no bubble).
- `flush`:
  - At the next edge: clear `out_valid`, force the FSM to IDLE, and discard any in-flight shift.
  - A request presented during the flush cycle is not accepted.
- Reset: all state clears immediately and asynchronously, including mid-shift.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `out_tag`=0, `out_illegal`=0, `busy`=0, state=IDLE. `in_ready`=1 after reset release, provided `flush`=0.
- Latency, non-shift: accept on edge T → `out_valid` at T (visible in cycle T+1).
- Latency, serial shift: `1 + ceil(shamt/SHIFT_STEP)` cycles, plus any output stall cycles.
- Throughput: 1 op/cycle for single-cycle ops with `out_ready`=1. `in_ready`=0 throughout SHIFT.
- `busy` equals (state==SHIFT). It is registered.
- `in_ready` is combinational from `out_ready` and `flush` only. There is no path from `in_valid` to `in_ready`.

## Structure
- `alu_pkg`:
  - `alu_op_e` (4-bit, encodings above).
  - `alu_state_e` {IDLE, SHIFT}.
  - `ALU_OP_ILLEGAL_MIN`=13.
  - Function `is_shift(alu_op_e)`.
- Sub-module `alu_comb`: combinational datapath for all non-shift ops, plus single-cycle shifts. Ports `a`, `b`, `op`, `result`, `illegal`; parameter XLEN.
- `alu_unit` owns the handshake, the output register, the serial shifter and the FSM.

## Test plan
- ADD with a=0xFFFF_FFFF, b=2 (XLEN=32) → result 0x0000_0001, `out_illegal`=0, `out_valid` one cycle after accept. Same for SUB with a=0, b=1 → 0xFFFF_FFFF.
- SHIFT_STEP=4: SRA with a=0x8000_0000, b=13 → `busy` for 4 cycles; result 0xFFFC_0000 at latency 5. SRL with the same operands → 0x0004_0000.
- Back-to-back ADDs with `out_ready` held 0 for 3 cycles → first result held stable; `in_ready`=0 during the stall; no request lost or duplicated; tags stay in order.
- `flush` asserted during cycle 2 of an 8-cycle serial SLL → `out_valid` stays 0, `busy`=0 next cycle, next request accepted normally.
- `in_op`=14 with tag 0x1A → result 0, `out_illegal`=1, `out_tag`=0x1A; the following GEU with a=1, b=0xFFFF_FFFF → result 0.
- `rst_n` dropped mid-shift with `out_valid`=1 → all outputs go to their reset values asynchronously; first request after release completes normally.
